// File: rtl/hcc_fifo_serializer.sv
`default_nettype none
// ============================================================================
// Module   : hcc_fifo_serializer
// Function : Pops words from the HCC synchronous FIFO and sends each one
//            MSB-first on a single-bit line, then a parity bit, then one
//            idle gap cycle. Keeps a saturating count of completed words.
// Revision : 1.0 - initial release
// ============================================================================
module hcc_fifo_serializer #(
  parameter int WORDWIDTH  = 8,
  parameter int PARITY_ODD = 0,
  parameter int CNTWIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 rstb,
  input  logic                 enable_i,
  input  logic [WORDWIDTH-1:0] fifo_data_i,
  input  logic                 fifo_empty_i,
  output logic                 re_o,
  output logic                 ser_o,
  output logic                 frame_o,
  output logic                 busy_o,
  output logic [CNTWIDTH-1:0]  words_o
);

  localparam int                  c_BITCNTW    = $clog2(WORDWIDTH + 1);
  localparam logic [c_BITCNTW-1:0] c_LASTBIT   = c_BITCNTW'(WORDWIDTH - 1);
  localparam logic [c_BITCNTW-1:0] c_BITONE    = c_BITCNTW'(1);
  localparam logic [CNTWIDTH-1:0]  c_WORDSMAX  = '1;
  localparam logic [CNTWIDTH-1:0]  c_WORDSONE  = CNTWIDTH'(1);
  localparam logic                 c_PARINIT   = (PARITY_ODD != 0);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_PARITY = 2'd2,
    S_GAP    = 2'd3
  } state_t;

  state_t                 r_state;
  logic [WORDWIDTH-1:0]   r_shift;
  logic [c_BITCNTW-1:0]   r_bitCnt;
  logic                   r_parity;
  logic                   r_ser;
  logic                   r_frame;
  logic [CNTWIDTH-1:0]    r_words;
  logic                   w_pop;

  // A pop is only issued from IDLE, so fifo_data_i is next sampled at least
  // WORDWIDTH+3 cycles later, well after the FIFO read pointer has caught up.
  assign w_pop   = rstb & (r_state == S_IDLE) & enable_i & ~fifo_empty_i;
  assign re_o    = w_pop;
  assign ser_o   = r_ser;
  assign frame_o = r_frame;
  assign busy_o  = (r_state != S_IDLE);
  assign words_o = r_words;

  // Serializer state machine: capture on pop, shift data, emit parity, gap.
  always_ff @(posedge clk) begin
    if (!rstb) begin
      r_state  <= S_IDLE;
      r_shift  <= '0;
      r_bitCnt <= '0;
      r_parity <= 1'b0;
      r_ser    <= 1'b0;
      r_frame  <= 1'b0;
      r_words  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_ser   <= 1'b0;
          r_frame <= 1'b0;
          if (w_pop) begin
            // The MSB goes straight to the output register so it appears in
            // the first cycle after the pop; the remaining bits wait in the
            // shift register already aligned to the MSB position.
            r_ser    <= fifo_data_i[WORDWIDTH-1];
            r_shift  <= {fifo_data_i[WORDWIDTH-2:0], 1'b0};
            r_bitCnt <= '0;
            r_parity <= (^fifo_data_i) ^ c_PARINIT;
            r_frame  <= 1'b1;
            r_state  <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_frame <= 1'b1;
          if (r_bitCnt == c_LASTBIT) begin
            r_ser   <= r_parity;
            r_state <= S_PARITY;
          end else begin
            r_ser    <= r_shift[WORDWIDTH-1];
            r_shift  <= {r_shift[WORDWIDTH-2:0], 1'b0};
            r_bitCnt <= r_bitCnt + c_BITONE;
          end
        end
        S_PARITY: begin
          r_ser   <= 1'b0;
          r_frame <= 1'b0;
          if (r_words != c_WORDSMAX) begin
            r_words <= r_words + c_WORDSONE;
          end
          r_state <= S_GAP;
        end
        S_GAP: begin
          r_ser   <= 1'b0;
          r_frame <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_ser   <= 1'b0;
          r_frame <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hcc_fifo_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_hcc_fifo_serializer
// Function : Directed bench for hcc_fifo_serializer. Three instances share
//            one FIFO model: even parity/16-bit count, odd parity, and a
//            2-bit saturating count.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hcc_fifo_serializer;

  logic       clk = 1'b0;
  logic       rstb;
  logic       enable_i;
  logic [7:0] fifoData;
  logic       fifoEmpty;

  logic        reA, serA, frameA, busyA;
  logic [15:0] wordsA;
  logic        reB, serB, frameB, busyB;
  logic [15:0] wordsB;
  logic        reC, serC, frameC, busyC;
  logic [1:0]  wordsC;

  int nCmp = 0;
  int nErr = 0;

  logic [7:0] q[$];

  typedef struct {
    logic [7:0] data;
    logic       parEven;
    logic       parOdd;
    int         waitCycles;
    int         words;
    int         satWords;
  } vec_t;

  vec_t vecs[6];

  always #5 clk = ~clk;

  hcc_fifo_serializer #(.WORDWIDTH(8), .PARITY_ODD(0), .CNTWIDTH(16)) dutEven (
    .clk(clk), .rstb(rstb), .enable_i(enable_i), .fifo_data_i(fifoData),
    .fifo_empty_i(fifoEmpty), .re_o(reA), .ser_o(serA), .frame_o(frameA),
    .busy_o(busyA), .words_o(wordsA));

  hcc_fifo_serializer #(.WORDWIDTH(8), .PARITY_ODD(1), .CNTWIDTH(16)) dutOdd (
    .clk(clk), .rstb(rstb), .enable_i(enable_i), .fifo_data_i(fifoData),
    .fifo_empty_i(fifoEmpty), .re_o(reB), .ser_o(serB), .frame_o(frameB),
    .busy_o(busyB), .words_o(wordsB));

  hcc_fifo_serializer #(.WORDWIDTH(8), .PARITY_ODD(0), .CNTWIDTH(2)) dutSat (
    .clk(clk), .rstb(rstb), .enable_i(enable_i), .fifo_data_i(fifoData),
    .fifo_empty_i(fifoEmpty), .re_o(reC), .ser_o(serC), .frame_o(frameC),
    .busy_o(busyC), .words_o(wordsC));

  function automatic void updateFifo();
    fifoEmpty = (q.size() == 0);
    fifoData  = (q.size() != 0) ? q[0] : 8'h00;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // FIFO model: head advances shortly after each edge that closes a re_o cycle.
  initial begin
    forever begin
      @(posedge clk);
      if (reA) begin
        #1;
        if (q.size() != 0) void'(q.pop_front());
        updateFifo();
      end
    end
  end

  // Waits for a pop, then checks data bits, parity, gap and counters.
  task automatic sendWord(input logic [7:0] w, input logic pe, input logic po,
                          input int expWait, input int dropAt, input int rstAt,
                          input int expWords, input int expSat);
    int n;
    n = 0;
    #1;
    while (!reA && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("popSeen", reA, 1);
    check("popSameAllDuts", {reB, reC}, 2'b11);
    check("popBusyLow", busyA, 0);
    if (expWait >= 0) check("popSpacing", n, expWait);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == dropAt) enable_i = 1'b0;
      check("dataBit", serA, w[7-i]);
      check("dataBitOdd", serB, w[7-i]);
      check("frameData", frameA, 1);
      check("busyData", busyA, 1);
      check("reQuietData", reA, 0);
      if (i == rstAt) begin
        rstb = 1'b0;
        @(negedge clk);
        check("rstSer", {serA, serB, serC}, 3'b000);
        check("rstFrame", {frameA, frameB, frameC}, 3'b000);
        check("rstBusy", {busyA, busyB, busyC}, 3'b000);
        check("rstWordsA", wordsA, 0);
        check("rstWordsC", wordsC, 0);
        check("rstRe", {reA, reB, reC}, 3'b000);
        return;
      end
    end
    @(negedge clk);
    check("parityEven", serA, pe);
    check("parityOdd", serB, po);
    check("frameParity", frameA, 1);
    @(negedge clk);
    check("gapSer", serA, 0);
    check("gapFrame", frameA, 0);
    check("gapBusy", busyA, 1);
    check("wordsCount", wordsA, expWords);
    check("wordsOdd", wordsB, expWords);
    check("wordsSat", wordsC, expSat);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{8'hA5, 1'b0, 1'b1, 0, 1, 1};
    vecs[1] = '{8'h01, 1'b1, 1'b0, 1, 2, 2};
    vecs[2] = '{8'hFF, 1'b0, 1'b1, 1, 3, 3};
    vecs[3] = '{8'h80, 1'b1, 1'b0, 1, 4, 3};
    vecs[4] = '{8'h00, 1'b0, 1'b1, 1, 5, 3};
    vecs[5] = '{8'h03, 1'b0, 1'b1, 1, 6, 3};

    rstb     = 1'b0;
    enable_i = 1'b0;
    updateFifo();
    repeat (3) @(negedge clk);

    // Reset state, with a non-empty FIFO and enable high to show re_o masked.
    for (int i = 0; i < 6; i++) q.push_back(vecs[i].data);
    updateFifo();
    enable_i = 1'b1;
    #1;
    check("resetRe", reA, 0);
    check("resetSer", serA, 0);
    check("resetFrame", frameA, 0);
    check("resetBusy", busyA, 0);
    check("resetWords", wordsA, 0);
    @(negedge clk);
    rstb = 1'b1;

    // Back-to-back words from the table.
    for (int i = 0; i < 6; i++) begin
      sendWord(vecs[i].data, vecs[i].parEven, vecs[i].parOdd, vecs[i].waitCycles,
               -1, -1, vecs[i].words, vecs[i].satWords);
    end

    // FIFO drained: stay idle.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("emptyRe", reA, 0);
      check("emptyBusy", busyA, 0);
      check("emptySerFrame", {serA, frameA}, 2'b00);
    end

    // Enable dropped during the third data bit of the first of four words.
    q.push_back(8'h3D); q.push_back(8'h5A); q.push_back(8'hC7); q.push_back(8'h96);
    updateFifo();
    sendWord(8'h3D, 1'b1, 1'b0, -1, 2, -1, 7, 3);
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      check("disabledRe", reA, 0);
    end
    check("disabledBusy", busyA, 0);
    enable_i = 1'b1;
    sendWord(8'h5A, 1'b0, 1'b1, 0, -1, -1, 8, 3);
    sendWord(8'hC7, 1'b1, 1'b0, 1, -1, -1, 9, 3);
    sendWord(8'h96, 1'b0, 1'b1, 1, -1, -1, 10, 3);

    // Reset during the fifth data bit; the aborted word is not resent.
    @(negedge clk);
    q.push_back(8'hE4); q.push_back(8'h2B);
    updateFifo();
    sendWord(8'hE4, 1'b0, 1'b0, -1, -1, 4, 0, 0);
    #1;
    check("rstHoldRe", reA, 0);
    rstb = 1'b1;
    sendWord(8'h2B, 1'b0, 1'b1, 0, -1, -1, 1, 1);

    repeat (3) @(negedge clk);
    check("finalIdle", busyA, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
`default_nettype wire
